// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, FSM states and datapath control encodings for the multi-cycle RV64I controller.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        C_ALU,
        C_ALUI,
        C_LOAD,
        C_STORE,
        C_LUI,
        C_AUIPC,
        C_JAL,
        C_JALR,
        C_BRANCH,
        C_ILLEGAL
    } class_e;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_RTYPE = 2'd2;
    localparam logic [1:0] ALU_ITYPE = 2'd3;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] SRCA_RS1  = 2'd0;
    localparam logic [1:0] SRCA_PC   = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    // funct3[2] picks the lt/ltu family, funct3[1] unsigned, funct3[0] inverts the sense
    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic lt,
                                          input logic ltu);
        return f3[2] ? ((f3[1] ? ltu : lt) ^ f3[0]) : (z ^ f3[0]);
    endfunction

endpackage

// File: rtl/instr_class_decoder.sv
// instr_class_decoder: classifies an RV64I opcode, selects its immediate format and flags legality.
module instr_class_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter bit SUPPORT_W = 1'b1
) (
    input  logic [6:0] opcode_i,
    input  logic [1:0] f3_hi_i,
    output class_e     cls_o,
    output logic [2:0] imm_sel_o,
    output logic       legal_o,
    output logic       br_ok_o
);

    always_comb begin
        cls_o     = C_ILLEGAL;
        imm_sel_o = IMM_I;
        case (opcode_i)
            OP_REG:    cls_o = C_ALU;
            OP_32:     cls_o = SUPPORT_W ? C_ALU : C_ILLEGAL;
            OP_IMM:    cls_o = C_ALUI;
            OP_IMM_32: cls_o = SUPPORT_W ? C_ALUI : C_ILLEGAL;
            OP_LOAD:   cls_o = C_LOAD;
            OP_JALR:   cls_o = C_JALR;
            OP_STORE: begin
                cls_o     = C_STORE;
                imm_sel_o = IMM_S;
            end
            OP_BRANCH: begin
                cls_o     = C_BRANCH;
                imm_sel_o = IMM_B;
            end
            OP_LUI: begin
                cls_o     = C_LUI;
                imm_sel_o = IMM_U;
            end
            OP_AUIPC: begin
                cls_o     = C_AUIPC;
                imm_sel_o = IMM_U;
            end
            OP_JAL: begin
                cls_o     = C_JAL;
                imm_sel_o = IMM_J;
            end
            default: ;
        endcase
    end

    assign legal_o = cls_o != C_ILLEGAL;
    // funct3 010/011 are the only undefined branch encodings
    assign br_ok_o = f3_hi_i != 2'b01;

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle RV64I control FSM sequencing FETCH/DECODE/EXEC/MEM/WB,
// driving every datapath mux and enable and handshaking with the unified memory.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit SUPPORT_W = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        alu_ltu,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [2:0]  imm_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        instr_done,
    output logic        trap,
    output logic [2:0]  state
);

    state_e     state_q, state_d, next_run;
    class_e     cls;
    logic [2:0] cls_imm;
    logic       legal, br_ok, taken, is_store;
    logic [1:0] a_sel, b_sel, op_sel;
    logic       unused_instr;

    instr_class_decoder #(.SUPPORT_W(SUPPORT_W)) u_dec (
        .opcode_i (instr[6:0]),
        .f3_hi_i  (instr[14:13]),
        .cls_o    (cls),
        .imm_sel_o(cls_imm),
        .legal_o  (legal),
        .br_ok_o  (br_ok)
    );

    assign unused_instr = ^{instr[31:15], instr[11:7]};
    assign taken        = branch_taken(instr[14:12], alu_zero, alu_lt, alu_ltu);
    assign is_store     = cls == C_STORE;
    assign next_run     = run ? S_FETCH : S_IDLE;
    assign state        = state_q;
    assign trap         = state_q == S_TRAP;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = next_run;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
            S_EXEC:   state_d = cls == C_BRANCH ? (br_ok ? next_run : S_TRAP)
                              : (cls inside {C_LOAD, C_STORE}) ? S_MEM : S_WB;
            S_MEM:    state_d = !mem_ready ? S_MEM : is_store ? next_run : S_WB;
            S_WB:     state_d = next_run;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    // ALU setup is held from EXEC through WB so address and jump targets stay valid
    always_comb begin
        a_sel  = SRCA_RS1;
        b_sel  = SRCB_IMM;
        op_sel = ALU_ADD;
        case (cls)
            C_ALU: begin
                b_sel  = SRCB_RS2;
                op_sel = ALU_RTYPE;
            end
            C_ALUI:  op_sel = ALU_ITYPE;
            C_LUI:   a_sel  = SRCA_ZERO;
            C_AUIPC: a_sel  = SRCA_PC;
            C_BRANCH: begin
                b_sel  = SRCB_RS2;
                op_sel = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS4;
        imm_sel    = IMM_I;
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        wb_sel     = WB_ALU;
        instr_done = 1'b0;
        if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
            alu_src_a = a_sel;
            alu_src_b = b_sel;
            alu_op    = op_sel;
            imm_sel   = cls_imm;
        end
        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
            end
            S_EXEC: begin
                pc_write   = cls == C_BRANCH && br_ok;
                instr_done = cls == C_BRANCH && br_ok;
                pc_src     = cls == C_BRANCH && taken ? PC_IMM : PC_PLUS4;
            end
            S_MEM: begin
                mem_req    = 1'b1;
                addr_sel   = 1'b1;
                mem_we     = is_store;
                pc_write   = is_store && mem_ready;
                instr_done = is_store && mem_ready;
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                wb_sel     = cls == C_LOAD ? WB_MEM : (cls inside {C_JAL, C_JALR}) ? WB_PC4 : WB_ALU;
                pc_src     = cls == C_JAL ? PC_IMM : cls == C_JALR ? PC_ALU : PC_PLUS4;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for the multi-cycle RV64I controller.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset, run, alu_zero, alu_lt, alu_ltu, mem_ready;
    logic [31:0] instr;
    logic        mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write, instr_done, trap;
    logic [1:0]  pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
    logic [2:0]  imm_sel, state;
    logic        w_mem_req, w_mem_we, w_addr_sel, w_ir_write, w_pc_write, w_reg_write, w_instr_done, w_trap;
    logic [1:0]  w_pc_src, w_alu_src_a, w_alu_src_b, w_alu_op, w_wb_sel;
    logic [2:0]  w_imm_sel, w_state;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req, mem_we, addr_sel, ir_write, pc_write;
        logic [1:0] pc_src;
        logic [2:0] imm_sel;
        logic [1:0] alu_src_a, alu_src_b, alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       instr_done, trap;
    } snap_t;

    typedef struct {
        int         cyc;
        logic [1:0] wb;
        logic [1:0] pc;
        logic       rw;
    } exp_t;

    snap_t      cur, exec_s, mem_s, wb_s;
    exp_t       sb[$];
    logic [2:0] sts[$];
    int         checks = 0, failures = 0, fc, mc, idle_cnt;
    bit         any_rw, viol;

    assign cur = {state, mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, imm_sel,
                  alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, instr_done, trap};

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .run(run), .instr(instr), .alu_zero(alu_zero), .alu_lt(alu_lt),
        .alu_ltu(alu_ltu), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .imm_sel(imm_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .wb_sel(wb_sel), .instr_done(instr_done), .trap(trap), .state(state)
    );

    multicycle_controller #(.SUPPORT_W(1'b0)) dut_w0 (
        .clk(clk), .reset(reset), .run(run), .instr(instr), .alu_zero(alu_zero), .alu_lt(alu_lt),
        .alu_ltu(alu_ltu), .mem_ready(mem_ready), .mem_req(w_mem_req), .mem_we(w_mem_we),
        .addr_sel(w_addr_sel), .ir_write(w_ir_write), .pc_write(w_pc_write), .pc_src(w_pc_src),
        .imm_sel(w_imm_sel), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_op(w_alu_op),
        .reg_write(w_reg_write), .wb_sel(w_wb_sel), .instr_done(w_instr_done), .trap(w_trap),
        .state(w_state)
    );

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0; instr = 32'h0000_0013;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // Runs one instruction to retirement; memory answers after fw/mw wait cycles.
    task automatic exec_instr(input logic [31:0] ir, input int fw, input int mw, input logic z,
                              input logic lt, input logic ltu, input bit drop_run, input int exp_cyc,
                              input logic [1:0] exp_wb, input logic [1:0] exp_pc, input logic exp_rw);
        exp_t e;
        int   cyc;
        bit   done;
        e = '{cyc: exp_cyc, wb: exp_wb, pc: exp_pc, rw: exp_rw};
        sb.push_back(e);
        instr = ir; alu_zero = z; alu_lt = lt; alu_ltu = ltu; run = 1'b1;
        cyc = 0; done = 0; fc = 0; mc = 0; idle_cnt = 0; any_rw = 0; viol = 0;
        sts.delete();
        for (int k = 0; k < 40 && !done; k++) begin
            mem_ready = !mem_req ? 1'b1 : addr_sel ? (mc >= mw) : (fc >= fw);
            @(negedge clk);
            if (state == 3'd0) idle_cnt++;
            else begin
                cyc++;
                sts.push_back(state);
                if (mem_req && !addr_sel) fc++;
                if (mem_req && addr_sel) begin mc++; mem_s = cur; end
                if (state == 3'd3) exec_s = cur;
                if (state == 3'd5) wb_s = cur;
                any_rw |= reg_write;
                if (mem_req && (reg_write || (pc_write && !(state == 3'd4 && mem_we)))) viol = 1;
                if (drop_run) run = 1'b0;
            end
            if (instr_done) begin
                e = sb.pop_front();
                checks++;
                if (cyc !== e.cyc || pc_src !== e.pc || reg_write !== e.rw || (e.rw && wb_sel !== e.wb)) begin
                    failures++;
                    $display("FAIL retire %h: cycles=%0d pc_src=%0d reg_write=%0b wb_sel=%0d, expected cycles=%0d pc_src=%0d reg_write=%0b wb_sel=%0d",
                             ir, cyc, pc_src, reg_write, wb_sel, e.cyc, e.pc, e.rw, e.wb);
                end
                done = 1;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!done || viol) begin
            failures++;
            $display("FAIL bound %h: retired=%0b enable_with_req=%0b, expected retired=1 enable_with_req=0", ir, done, viol);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; mem_ready = 1'b0; instr = 32'h0050_0093;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cur !== '0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", cur); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (state !== 3'd1 || mem_req !== 1'b1) begin
            failures++; $display("FAIL fetch_start: state=%0d mem_req=%0b expected 1 1", state, mem_req);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (cur !== '0) begin failures++; $display("FAIL async_reset: got %h expected 0", cur); end
        @(posedge clk); #1;
        reset = 1'b0; run = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (cur !== '0) begin failures++; $display("FAIL idle_hold: got %h expected 0", cur); end
    endtask

    task automatic test_alu();
        do_reset();
        exec_instr(32'h0050_0093, 0, 0, 0, 0, 0, 0, 4, 2'd0, 2'd0, 1'b1);
        checks++;
        if (sts.size() != 4 || {sts[0], sts[1], sts[2], sts[3]} !== 12'o1235) begin
            failures++; $display("FAIL addi_states: n=%0d got %o expected 1235", sts.size(), {sts[0], sts[1], sts[2], sts[3]});
        end
        checks++;
        if (exec_s.alu_src_a !== 2'd0 || exec_s.alu_src_b !== 2'd1 || exec_s.alu_op !== 2'd3 || exec_s.imm_sel !== 3'd0) begin
            failures++; $display("FAIL addi_exec: a=%0d b=%0d op=%0d imm=%0d expected 0 1 3 0",
                                 exec_s.alu_src_a, exec_s.alu_src_b, exec_s.alu_op, exec_s.imm_sel);
        end
        checks++;
        if (!wb_s.reg_write || wb_s.wb_sel !== 2'd0 || !wb_s.pc_write || !wb_s.instr_done || wb_s.pc_src !== 2'd0 || wb_s.mem_req) begin
            failures++; $display("FAIL addi_wb: snapshot %h", wb_s);
        end
        exec_instr(32'h1234_50B7, 0, 0, 0, 0, 0, 0, 4, 2'd0, 2'd0, 1'b1);
        checks++;
        if (exec_s.alu_src_a !== 2'd2 || exec_s.alu_src_b !== 2'd1 || exec_s.imm_sel !== 3'd3) begin
            failures++; $display("FAIL lui_exec: a=%0d b=%0d imm=%0d expected 2 1 3", exec_s.alu_src_a, exec_s.alu_src_b, exec_s.imm_sel);
        end
        exec_instr(32'h0000_0097, 0, 0, 0, 0, 0, 0, 4, 2'd0, 2'd0, 1'b1);
        checks++;
        if (exec_s.alu_src_a !== 2'd1 || exec_s.alu_src_b !== 2'd1 || exec_s.imm_sel !== 3'd3) begin
            failures++; $display("FAIL auipc_exec: a=%0d b=%0d imm=%0d expected 1 1 3", exec_s.alu_src_a, exec_s.alu_src_b, exec_s.imm_sel);
        end
        exec_instr(32'h0020_81B3, 0, 0, 0, 0, 0, 0, 4, 2'd0, 2'd0, 1'b1);
        checks++;
        if (exec_s.alu_src_a !== 2'd0 || exec_s.alu_src_b !== 2'd0 || exec_s.alu_op !== 2'd2) begin
            failures++; $display("FAIL add_exec: a=%0d b=%0d op=%0d expected 0 0 2", exec_s.alu_src_a, exec_s.alu_src_b, exec_s.alu_op);
        end
        checks++;
        if (idle_cnt != 0) begin failures++; $display("FAIL back_to_back: idle=%0d expected 0", idle_cnt); end
        exec_instr(32'h0000_003B, 0, 0, 0, 0, 0, 0, 4, 2'd0, 2'd0, 1'b1);
        checks++;
        if (exec_s.alu_op !== 2'd2 || w_state !== 3'd6 || w_trap !== 1'b1) begin
            failures++; $display("FAIL addw: op=%0d w0_state=%0d w0_trap=%0b expected 2 6 1", exec_s.alu_op, w_state, w_trap);
        end
    endtask

    task automatic test_load();
        do_reset();
        exec_instr(32'h0000_A103, 2, 2, 0, 0, 0, 0, 9, 2'd1, 2'd0, 1'b1);
        checks++;
        if (fc != 3 || mc != 3) begin failures++; $display("FAIL lw_req_hold: fetch=%0d mem=%0d expected 3 3", fc, mc); end
        checks++;
        if (!mem_s.addr_sel || mem_s.mem_we || mem_s.pc_write || exec_s.alu_src_b !== 2'd1 || exec_s.alu_op !== 2'd0) begin
            failures++; $display("FAIL lw_mem: mem %h exec %h", mem_s, exec_s);
        end
        checks++;
        if (wb_s.wb_sel !== 2'd1) begin failures++; $display("FAIL lw_wb_sel: got %0d expected 1", wb_s.wb_sel); end
        exec_instr(32'h0000_B103, 0, 0, 0, 0, 0, 0, 5, 2'd1, 2'd0, 1'b1);
    endtask

    task automatic test_store();
        int k;
        do_reset();
        exec_instr(32'h0011_3023, 0, 1, 0, 0, 0, 0, 5, 2'd0, 2'd0, 1'b0);
        checks++;
        if (!mem_s.mem_we || !mem_s.addr_sel || !mem_s.pc_write || !mem_s.instr_done || mem_s.pc_src !== 2'd0
            || exec_s.imm_sel !== 3'd1 || any_rw) begin
            failures++; $display("FAIL sd_mem: mem %h exec_imm=%0d reg_write_seen=%0b", mem_s, exec_s.imm_sel, any_rw);
        end
        do_reset();
        run = 1'b1; instr = 32'h0011_3023;
        for (k = 0; k < 20; k++) begin
            if (mem_req && addr_sel) break;
            mem_ready = mem_req;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        checks++;
        if (k >= 20 || !mem_we) begin failures++; $display("FAIL sd_reach_mem: steps=%0d mem_we=%0b expected <20 1", k, mem_we); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || state !== 3'd0) begin
            failures++; $display("FAIL sd_reset_drop: mem_req=%0b mem_we=%0b state=%0d expected 0 0 0", mem_req, mem_we, state);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (state !== 3'd1 || !mem_req || addr_sel) begin
            failures++; $display("FAIL sd_restart: state=%0d mem_req=%0b addr_sel=%0b expected 1 1 0", state, mem_req, addr_sel);
        end
    endtask

    task automatic test_branch();
        logic [31:0] irs[7] = '{32'h0000_0463, 32'h0000_0463, 32'h0000_1463, 32'h0000_4463,
                                32'h0000_5463, 32'h0000_6463, 32'h0000_7463};
        logic [2:0]  flg[7] = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000};
        logic [1:0]  epc[7] = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            exec_instr(irs[i], 0, 0, flg[i][2], flg[i][1], flg[i][0], 0, 3, 2'd0, epc[i], 1'b0);
            checks++;
            if (exec_s.alu_op !== 2'd1 || exec_s.imm_sel !== 3'd2 || !exec_s.pc_write || any_rw) begin
                failures++; $display("FAIL branch_%0d: op=%0d imm=%0d pc_write=%0b reg_write_seen=%0b expected 1 2 1 0",
                                     i, exec_s.alu_op, exec_s.imm_sel, exec_s.pc_write, any_rw);
            end
        end
    endtask

    task automatic test_jump();
        do_reset();
        exec_instr(32'h0080_00EF, 0, 0, 0, 0, 0, 0, 4, 2'd2, 2'd1, 1'b1);
        checks++;
        if (exec_s.imm_sel !== 3'd4 || wb_s.imm_sel !== 3'd4) begin
            failures++; $display("FAIL jal_imm: exec=%0d wb=%0d expected 4 4", exec_s.imm_sel, wb_s.imm_sel);
        end
        exec_instr(32'h0000_80E7, 0, 0, 0, 0, 0, 0, 4, 2'd2, 2'd2, 1'b1);
        checks++;
        if (exec_s.alu_src_a !== 2'd0 || exec_s.alu_src_b !== 2'd1 || exec_s.alu_op !== 2'd0 || exec_s.imm_sel !== 3'd0) begin
            failures++; $display("FAIL jalr_exec: a=%0d b=%0d op=%0d imm=%0d expected 0 1 0 0",
                                 exec_s.alu_src_a, exec_s.alu_src_b, exec_s.alu_op, exec_s.imm_sel);
        end
    endtask

    task automatic test_run_drop();
        do_reset();
        exec_instr(32'h0050_0093, 0, 0, 0, 0, 0, 1, 4, 2'd0, 2'd0, 1'b1);
        checks++;
        if (state !== 3'd0) begin failures++; $display("FAIL run_drop_idle: state=%0d expected 0", state); end
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (cur !== '0) begin failures++; $display("FAIL run_drop_hold: got %h expected 0", cur); end
    endtask

    task automatic test_trap();
        logic [31:0] irs[3] = '{32'h0000_007F, 32'h0000_2463, 32'h0010_809B};
        bit          retired;
        for (int i = 0; i < 3; i++) begin
            do_reset();
            run = 1'b1; mem_ready = 1'b1; instr = irs[i]; retired = 0;
            repeat (8) begin
                @(negedge clk);
                retired |= (i < 2) && instr_done;
                @(posedge clk); #1;
            end
            checks++;
            if (i < 2 && (state !== 3'd6 || trap !== 1'b1 || retired || mem_req || pc_write || reg_write || ir_write)) begin
                failures++; $display("FAIL trap_%0d: state=%0d trap=%0b retired=%0b expected 6 1 0", i, state, trap, retired);
            end else if (i == 2 && (w_state !== 3'd6 || w_trap !== 1'b1 || trap !== 1'b0)) begin
                failures++; $display("FAIL trap_w0: w0_state=%0d w0_trap=%0b main_trap=%0b expected 6 1 0", w_state, w_trap, trap);
            end
        end
        do_reset();
        checks++;
        if (cur !== '0 || w_state !== 3'd0) begin failures++; $display("FAIL trap_exit: got %h w0_state=%0d expected 0 0", cur, w_state); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_jump();
        test_run_drop();
        test_trap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM for the RV64I datapath (register file, ALU, immediate generator, unified memory).
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, drives every datapath mux and enable, and handshakes with memory.
- Sits between the instruction register and the datapath. It is the only block that writes the PC, IR and register file.

Parameters:
- SUPPORT_W, 1, when 1 the OP-32 (0111011) and OP-IMM-32 (0011011) opcodes are legal; when 0 they trap.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  start/continue execution.
- instr  input  32  IR contents; stable from DECODE until the next fetch completes.
- alu_zero  input  1  ALU result == 0.
- alu_lt  input  1  signed rs1 < rs2.
- alu_ltu  input  1  unsigned rs1 < rs2.
- mem_ready  input  1  memory has completed the current request.
- mem_req  output  1  memory request; held until mem_ready.
- mem_we  output  1  write request (store).
- addr_sel  output  1  memory address source: 0 = PC, 1 = ALU result.
- ir_write  output  1  load IR from memory read data.
- pc_write  output  1  update PC.
- pc_src  output  2  next-PC source: 0 = PC+4, 1 = PC+imm, 2 = ALU result with bit 0 cleared.
- imm_sel  output  3  immediate format: 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- alu_src_a  output  2  ALU operand A: 0 = rs1, 1 = PC, 2 = zero.
- alu_src_b  output  2  ALU operand B: 0 = rs2, 1 = imm, 2 = constant 4.
- alu_op  output  2  0 = add, 1 = sub, 2 = R-type funct decode, 3 = I-type funct decode.
- reg_write  output  1  register file write enable.
- wb_sel  output  2  write-back source: 0 = ALU, 1 = memory data, 2 = PC+4.
- instr_done  output  1  one-cycle pulse when an instruction retires.
- trap  output  1  illegal opcode seen; sticky.
- state  output  3  current state, for debug.

Behaviour:

State register and outputs:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Asynchronous reset forces IDLE.
- All outputs are Moore/combinational from state and instr fields. In IDLE every output is 0 (state=0), so every output reads 0 during and directly after reset.

Transitions:
- IDLE -> FETCH when run=1.
- FETCH:
  - Drives mem_req=1, addr_sel=0.
  - On mem_ready=1, asserts ir_write the same cycle and moves to DECODE; otherwise stays in FETCH.
- DECODE:
  - Classifies instr[6:0].
  - Legal opcodes go to EXEC; illegal ones go to TRAP.
- EXEC:
  - R / OP-32: src_a=0, src_b=0, alu_op=2 -> WB.
  - OP-IMM / OP-IMM-32: src_a=0, src_b=1, imm_sel=I, alu_op=3 -> WB.
  - LOAD / STORE: src_a=0, src_b=1, alu_op=0, imm_sel I or S -> MEM.
  - LUI: src_a=2, src_b=1, imm_sel=U -> WB.
  - AUIPC: src_a=1, src_b=1, imm_sel=U -> WB.
  - JAL: imm_sel=J -> WB.
  - JALR: src_a=0, src_b=1, imm_sel=I, alu_op=0 -> WB.
  - BRANCH (retires in EXEC):
    - Drives alu_op=1, imm_sel=B, pc_write=1, instr_done=1.
    - Taken = beq zero; bne !zero; blt lt; bge !lt; bltu ltu; bgeu !ltu.
    - pc_src=1 if taken, else 0.
    - Illegal funct3 (010/011) goes to TRAP instead.
- MEM:
  - Drives mem_req=1, addr_sel=1, mem_we=1 for stores; waits for mem_ready.
  - Load -> WB.
  - Store retires here: pc_write=1, pc_src=0, instr_done=1 in the mem_ready cycle.
- WB:
  - reg_write=1, pc_write=1, instr_done=1.
  - wb_sel: 1 for load, 2 for JAL/JALR, 0 otherwise.
  - pc_src: 1 for JAL, 2 for JALR, 0 otherwise.
- TRAP: trap=1, all enables 0. Only reset exits TRAP.
- After retirement: next state is FETCH if run=1, else IDLE.

Latency with zero-wait memory:
- Branch: 3 cycles.
- Store, ALU ops, LUI/AUIPC/JAL/JALR: 4 cycles.
- Load: 5 cycles.
- Each mem_ready wait cycle adds 1.

Boundary rules:
- mem_ready while mem_req=0 is ignored.
- run is sampled only in IDLE and in retirement cycles; deasserting run mid-instruction does not abort it.
- reset in MEM or FETCH drops mem_req immediately (asynchronous); no write is issued.
- pc_write and reg_write are never asserted in the same cycle as mem_req unless the state is MEM for a store (pc_write only).

Decomposition:
- Package riscv_ctrl_pkg holds:
  - Opcode constants.
  - State encoding.
  - imm_sel, alu_op, pc_src, wb_sel and alu_src encodings.
- One combinational sub-module, instr_class_decoder:
  - Maps opcode/funct3 plus SUPPORT_W to an instruction class, imm_sel and a legal flag.
  - Used by DECODE and the following states.

Test Plan:
- Reset asserted mid-run -> all outputs 0 and state=0 asynchronously. Release with run=0 -> remains IDLE.
- run=1, ADDI 0x00500093, mem_ready always 1 -> cycles show states 1,2,3,5. EXEC has alu_src_b=1, alu_op=3. WB has reg_write=1, wb_sel=0, pc_write=1, instr_done=1.
- LW 0x0000A103 with mem_ready delayed 2 cycles in both FETCH and MEM -> instr_done 9 cycles after fetch start. WB has wb_sel=1. mem_req stays high through both waits.
- BEQ 0x00000463 with alu_zero=1 -> EXEC shows pc_src=1, instr_done. With alu_zero=0 -> pc_src=0. Neither case asserts reg_write.
- Opcode 0x7F, then OP-32 ADDW 0x0000003B with SUPPORT_W=0 -> trap=1 and state=6, held while run=1 until reset.
- Store SD 0x00113023 with reset pulsed during MEM wait -> mem_req and mem_we drop immediately, next start begins at FETCH.
